// File: rtl/riscv_ctrl_pipe.sv
// Main pipeline controller: decodes the IF/ID instruction into the ID/EX control register,
// inserts load-use bubbles, and applies branch flushes.
// Latency: controls appear on ex_* one edge after decode. A memory op in EX freezes the pipe for MEM_WAIT cycles.
module riscv_ctrl_pipe #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_WAIT   = 0,
  parameter int EN_AUIPC   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           id_instr,
  input  logic                  id_valid,
  input  logic                  branch_taken,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_ALUSrc,
  output logic                  ex_MemtoReg,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic                  ex_jal,
  output logic                  ex_jalr,
  output logic                  ex_auipc,
  output logic                  ex_illegal,
  output logic [1:0]            ex_ALUOp,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  mem_hold
);

  localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       illegal;
    logic [1:0] aluop;
  } ctrl_t;

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  ctrl_t                 dec, ex_q;
  logic                  use_rs1, use_rs2, hz;
  logic                  ld_bubble, ld_decode;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  unused_instr_bits;

  assign rs1 = id_instr[15 +: REG_ADDR_W];
  assign rs2 = id_instr[20 +: REG_ADDR_W];
  assign rd  = id_instr[7 +: REG_ADDR_W];
  assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:12]};

  // Opcode decode into the control bundle plus which source registers are read
  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_instr[6:0])
      OP_R:     begin dec.regwrite = 1'b1; dec.aluop = 2'b10; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I:     begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b10; use_rs1 = 1'b1; end
      OP_LW:    begin dec.alusrc = 1'b1; dec.memtoreg = 1'b1; dec.regwrite = 1'b1; dec.memread = 1'b1; use_rs1 = 1'b1; end
      OP_SW:    begin dec.alusrc = 1'b1; dec.memwrite = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BR:    begin dec.branch = 1'b1; dec.aluop = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LUI:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11; end
      OP_JAL:   begin dec.regwrite = 1'b1; dec.jal = 1'b1; dec.aluop = 2'b11; end
      OP_JALR:  begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.jalr = 1'b1; use_rs1 = 1'b1; end
      OP_AUIPC: begin
        if (EN_AUIPC != 0) begin
          dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.auipc = 1'b1; dec.aluop = 2'b11;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      default:  dec.illegal = 1'b1;
    endcase
  end

  // Load-use hazard: the load in EX writes a register the ID instruction reads; x0 never counts
  assign hz = id_valid & ex_valid & ex_q.memread & (ex_rd != '0) &
              ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a memory op leaving EX opens a wait window of MEM_WAIT cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RUN: begin
        if (ex_valid & (ex_q.memread | ex_q.memwrite) & (MEM_WAIT > 0)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RUN;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Outputs: pipeline enables and what ID/EX loads; redirect outranks the hazard stall
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    mem_hold   = 1'b0;
    ld_bubble  = 1'b0;
    ld_decode  = 1'b0;
    case (state)
      S_RUN: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          ld_bubble  = 1'b1;
        end else if (hz) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ld_bubble  = 1'b1;
        end else begin
          ld_decode  = 1'b1;
        end
      end
      default: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        mem_hold   = 1'b1;
      end
    endcase
  end

  // ID/EX control register: bubble, load, or hold while the memory wait is open
  always_ff @(posedge clk) begin
    if (reset || ld_bubble) begin
      ex_q     <= '0;
      ex_valid <= 1'b0;
      ex_rd    <= '0;
    end else if (ld_decode) begin
      ex_q     <= id_valid ? dec : '0;
      ex_valid <= id_valid;
      ex_rd    <= rd;
    end
  end

  assign ex_ALUSrc   = ex_q.alusrc;
  assign ex_MemtoReg = ex_q.memtoreg;
  assign ex_RegWrite = ex_q.regwrite;
  assign ex_MemRead  = ex_q.memread;
  assign ex_MemWrite = ex_q.memwrite;
  assign ex_Branch   = ex_q.branch;
  assign ex_jal      = ex_q.jal;
  assign ex_jalr     = ex_q.jalr;
  assign ex_auipc    = ex_q.auipc;
  assign ex_illegal  = ex_q.illegal;
  assign ex_ALUOp    = ex_q.aluop;

endmodule

// File: tb/tb_riscv_ctrl_pipe.sv
// Bench for riscv_ctrl_pipe: two instances (MEM_WAIT=0/EN_AUIPC=0 and MEM_WAIT=3/EN_AUIPC=1)
// share one stimulus stream. A cycle-level reference model predicts the ID/EX contents and the enables.
// Directed scenarios come first, then a randomized instruction stream.
module tb_riscv_ctrl_pipe;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111, OP_AUIPC = 7'b0010111,
                         OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, branch_taken;
  logic [31:0] id_instr;

  logic [1:0]  o_v, o_als, o_mtr, o_rw, o_mr, o_mw, o_br, o_jal, o_jalr, o_aui, o_ill;
  logic [1:0]  o_pw, o_iw, o_fl, o_mh;
  logic [1:0]  o_aluop [2];
  logic [4:0]  o_rd [2];
  logic [11:0] o_ctl [2];

  assign o_ctl[0] = {o_als[0], o_mtr[0], o_rw[0], o_mr[0], o_mw[0], o_br[0],
                     o_jal[0], o_jalr[0], o_aui[0], o_ill[0], o_aluop[0]};
  assign o_ctl[1] = {o_als[1], o_mtr[1], o_rw[1], o_mr[1], o_mw[1], o_br[1],
                     o_jal[1], o_jalr[1], o_aui[1], o_ill[1], o_aluop[1]};

  riscv_ctrl_pipe #(.REG_ADDR_W(5), .MEM_WAIT(0), .EN_AUIPC(0)) dut0 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .branch_taken(branch_taken),
    .ex_valid(o_v[0]), .ex_rd(o_rd[0]), .ex_ALUSrc(o_als[0]), .ex_MemtoReg(o_mtr[0]),
    .ex_RegWrite(o_rw[0]), .ex_MemRead(o_mr[0]), .ex_MemWrite(o_mw[0]), .ex_Branch(o_br[0]),
    .ex_jal(o_jal[0]), .ex_jalr(o_jalr[0]), .ex_auipc(o_aui[0]), .ex_illegal(o_ill[0]),
    .ex_ALUOp(o_aluop[0]), .pc_write(o_pw[0]), .ifid_write(o_iw[0]), .ifid_flush(o_fl[0]),
    .mem_hold(o_mh[0]));

  riscv_ctrl_pipe #(.REG_ADDR_W(5), .MEM_WAIT(3), .EN_AUIPC(1)) dut1 (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .branch_taken(branch_taken),
    .ex_valid(o_v[1]), .ex_rd(o_rd[1]), .ex_ALUSrc(o_als[1]), .ex_MemtoReg(o_mtr[1]),
    .ex_RegWrite(o_rw[1]), .ex_MemRead(o_mr[1]), .ex_MemWrite(o_mw[1]), .ex_Branch(o_br[1]),
    .ex_jal(o_jal[1]), .ex_jalr(o_jalr[1]), .ex_auipc(o_aui[1]), .ex_illegal(o_ill[1]),
    .ex_ALUOp(o_aluop[1]), .pc_write(o_pw[1]), .ifid_write(o_iw[1]), .ifid_flush(o_fl[1]),
    .mem_hold(o_mh[1]));

  // Reference state: what each ID/EX register holds, and how many wait cycles remain
  logic [11:0] m_ctl  [2];
  logic [4:0]  m_rd   [2];
  logic        m_v    [2];
  int          m_wait [2];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic int mw_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  // Control bundle {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,jal,jalr,auipc,illegal,ALUOp}
  function automatic logic [11:0] ref_ctl(input logic [6:0] op, input bit en_auipc);
    case (op)
      OP_R:     return 12'b001000000010;
      OP_I:     return 12'b101000000010;
      OP_LW:    return 12'b111100000000;
      OP_SW:    return 12'b100010000000;
      OP_BR:    return 12'b000001000001;
      OP_LUI:   return 12'b101000000011;
      OP_JAL:   return 12'b001000100011;
      OP_JALR:  return 12'b101000010000;
      OP_AUIPC: return en_auipc ? 12'b101000001011 : 12'b000000000100;
      default:  return 12'b000000000100;
    endcase
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JALR};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_SW, OP_BR};
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, op};
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endtask

  // Apply one cycle of inputs, compare both DUTs against the model, then advance the model
  task automatic cycle(input bit r, input bit v, input logic [31:0] ins, input bit b);
    bit         wt, hz, start;
    logic [3:0] exp_en;
    @(negedge clk);
    reset = r; id_valid = v; id_instr = ins; branch_taken = b;
    #1;
    for (int i = 0; i < 2; i++) begin
      wt = (m_wait[i] > 0);
      hz = v && m_v[i] && m_ctl[i][8] && (m_rd[i] != 5'd0) &&
           ((reads_rs1(ins[6:0]) && ins[19:15] == m_rd[i]) ||
            (reads_rs2(ins[6:0]) && ins[24:20] == m_rd[i]));
      // {pc_write, ifid_write, ifid_flush, mem_hold}
      exp_en = wt ? 4'b0001 : b ? 4'b1110 : hz ? 4'b0000 : 4'b1100;
      chk("ex_valid", i, 32'(o_v[i]), 32'(m_v[i]));
      chk("ex_ctrl", i, 32'(o_ctl[i]), 32'(m_ctl[i]));
      if (m_v[i]) chk("ex_rd", i, 32'(o_rd[i]), 32'(m_rd[i]));
      chk("enables", i, 32'({o_pw[i], o_iw[i], o_fl[i], o_mh[i]}), 32'(exp_en));
      start = m_v[i] && (m_ctl[i][8] || m_ctl[i][7]) && (mw_of(i) > 0);
      if (r) begin
        m_v[i] = 1'b0; m_ctl[i] = '0; m_rd[i] = '0; m_wait[i] = 0;
      end else if (wt) begin
        m_wait[i] = m_wait[i] - 1;
      end else begin
        if (b || hz) begin
          m_v[i] = 1'b0; m_ctl[i] = '0; m_rd[i] = '0;
        end else begin
          m_v[i] = v; m_ctl[i] = v ? ref_ctl(ins[6:0], i == 1) : 12'b0; m_rd[i] = ins[11:7];
        end
        if (start) m_wait[i] = mw_of(i);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'b0, 1'b0);
  endtask

  logic [6:0]  ops [10] = '{OP_LUI, OP_AUIPC, OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_BAD};
  logic [31:0] lw5, add6, x;
  int          mh0, mh1;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_ctl[i] = '0; m_rd[i] = '0; m_wait[i] = 0;
    end
    reset = 1'b1; id_valid = 1'b0; id_instr = '0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1'b1, 1'b1, mk(OP_LW, 5'd4, 5'd1, 5'd1), 1'b1);
    cycle(1'b0, 1'b0, 32'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 32'(o_v[i]), 32'd0);
      chk("rst_ctrl", i, 32'(o_ctl[i]), 32'd0);
      chk("rst_enables", i, 32'({o_pw[i], o_iw[i], o_fl[i], o_mh[i]}), 32'b1100);
    end

    // Decode sweep
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b1, mk(ops[k], 5'd3, 5'd2, 5'd1), 1'b0);
      cycle(1'b0, 1'b0, 32'b0, 1'b0);
      if (ops[k] == OP_AUIPC) begin
        chk("auipc_dec", 1, 32'(o_ctl[1]), 32'b101000001011);
        chk("auipc_off", 0, 32'(o_ctl[0]), 32'b000000000100);
      end
      if (ops[k] == OP_BAD) chk("bad_dec", 1, 32'(o_ctl[1]), 32'b000000000100);
      if (ops[k] == OP_LW)  chk("lw_dec", 1, 32'(o_ctl[1]), 32'b111100000000);
      if (ops[k] == OP_JAL) chk("jal_dec", 1, 32'(o_ctl[1]), 32'b001000100011);
      idle(4);
    end

    // Load-use stall
    lw5  = mk(OP_LW, 5'd5, 5'd2, 5'd0);
    add6 = mk(OP_R, 5'd6, 5'd5, 5'd1);
    cycle(1'b0, 1'b1, lw5, 1'b0);
    cycle(1'b0, 1'b1, add6, 1'b0);
    chk("hz_stall", 0, 32'({o_pw[0], o_iw[0], o_fl[0], o_mh[0]}), 32'b0000);
    chk("hz_stall", 1, 32'({o_pw[1], o_iw[1], o_fl[1], o_mh[1]}), 32'b0000);
    cycle(1'b0, 1'b1, add6, 1'b0);
    chk("hz_bubble", 0, 32'(o_v[0]), 32'd0);
    cycle(1'b0, 1'b1, add6, 1'b0);
    chk("add_in_ex", 0, 32'({o_v[0], o_rd[0]}), 32'({1'b1, 5'd6}));
    idle(5);
    // lw x0 never stalls
    cycle(1'b0, 1'b1, mk(OP_LW, 5'd0, 5'd2, 5'd0), 1'b0);
    cycle(1'b0, 1'b1, mk(OP_R, 5'd6, 5'd0, 5'd0), 1'b0);
    chk("x0_nostall", 0, 32'({o_pw[0], o_iw[0], o_fl[0], o_mh[0]}), 32'b1100);
    idle(5);

    // LUI/JAL do not read rs1/rs2, even when those fields match
    cycle(1'b0, 1'b1, lw5, 1'b0);
    cycle(1'b0, 1'b1, mk(OP_LUI, 5'd5, 5'd5, 5'd5), 1'b0);
    chk("lui_nostall", 0, 32'(o_pw[0]), 32'd1);
    idle(5);
    cycle(1'b0, 1'b1, lw5, 1'b0);
    cycle(1'b0, 1'b1, mk(OP_JAL, 5'd1, 5'd5, 5'd5), 1'b0);
    chk("jal_nostall", 0, 32'(o_pw[0]), 32'd1);
    idle(5);

    // Flush outranks a simultaneous load-use hazard
    cycle(1'b0, 1'b1, lw5, 1'b0);
    cycle(1'b0, 1'b1, add6, 1'b1);
    chk("flush_prio", 0, 32'({o_pw[0], o_iw[0], o_fl[0], o_mh[0]}), 32'b1110);
    chk("flush_prio", 1, 32'({o_pw[1], o_iw[1], o_fl[1], o_mh[1]}), 32'b1110);
    cycle(1'b0, 1'b0, 32'b0, 1'b0);
    chk("flush_bubble", 0, 32'(o_v[0]), 32'd0);
    idle(5);

    // sw then lw with MEM_WAIT=3: 6 hold cycles, redirect inside WAIT ignored
    mh0 = 0; mh1 = 0;
    cycle(1'b0, 1'b1, mk(OP_SW, 5'd3, 5'd2, 5'd1), 1'b0);
    cycle(1'b0, 1'b1, mk(OP_LW, 5'd9, 5'd2, 5'd0), 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 1'b0, 32'b0, k == 1);
      if (k == 3) chk("lw_survives", 1, 32'({o_v[1], o_ctl[1], o_rd[1]}),
                      32'({1'b1, 12'b111100000000, 5'd9}));
      mh0 += int'(o_mh[0]);
      mh1 += int'(o_mh[1]);
    end
    chk("hold_cycles", 1, 32'(mh1), 32'd6);
    chk("hold_cycles", 0, 32'(mh0), 32'd0);
    idle(2);

    // Reset in the second wait cycle
    cycle(1'b0, 1'b1, mk(OP_LW, 5'd7, 5'd2, 5'd0), 1'b0);
    cycle(1'b0, 1'b0, 32'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'b0, 1'b0);
    chk("in_wait", 1, 32'(o_mh[1]), 32'd1);
    cycle(1'b0, 1'b0, 32'b0, 1'b0);
    chk("rst_abort", 1, 32'({o_v[1], o_ctl[1], o_pw[1], o_mh[1]}), 32'({1'b0, 12'b0, 1'b1, 1'b0}));

    // Randomized stream with a small register pool to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      x = $urandom;
      x[6:0]   = ($urandom_range(0, 3) == 0) ? OP_LW : ops[$urandom_range(0, 9)];
      x[11:7]  = 5'($urandom_range(0, 3));
      x[19:15] = 5'($urandom_range(0, 3));
      x[24:20] = 5'($urandom_range(0, 3));
      cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, x, $urandom_range(0, 99) < 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
